// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the regfile writeback arbiter: register address, data word, request payload.
package regfile_wb_arbiter_pkg;

  typedef logic [4:0]  regaddr_t;
  typedef logic [31:0] size_t;

  localparam int REG_COUNT = 32;

  typedef struct packed {
    regaddr_t addr;
    size_t    data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// One-hot grant selection for the writeback requesters.
// REGFILE_WB_RR_EN selects round-robin with a rotating pointer; otherwise fixed priority (index 0 wins).
module wb_rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         valid,
`ifdef REGFILE_WB_RR_EN
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] next_ptr,
`endif
  output logic [N-1:0]         grant
);

`ifdef REGFILE_WB_RR_EN
  localparam int PW = $clog2(N);

  // Scan starting at ptr; the winner's successor becomes the new top priority.
  always_comb begin
    int   idx;
    logic found;
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        next_ptr   = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end
`else
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && valid[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: serialises N_REQ sources onto the regfile write port and tracks pending writes.
// Optional macro REGFILE_WB_RR_EN enables round-robin arbitration (default: fixed priority).
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                   clk,
  input  logic                   reset_n_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  regaddr_t [N_REQ-1:0]   req_addr_i,
  input  size_t    [N_REQ-1:0]   req_data_i,
  input  logic                   rsv_valid_i,
  input  regaddr_t               rsv_addr_i,
  input  regaddr_t               rd_addr_1_i,
  input  regaddr_t               rd_addr_2_i,
  output logic                   hazard_o,
  output logic [REG_COUNT-1:0]   pending_o,
  output logic                   wr_enable_o,
  output regaddr_t               wr_addr_o,
  output size_t                  wr_data_o
);

  // Handshake: a source raises valid with stable addr/data and holds it until the
  // cycle where ready is high; the transfer happens at that posedge (valid & ready).
  logic [N_REQ-1:0]     grant;
  logic                 accept;
  wb_req_t              sel;
  logic [REG_COUNT-1:0] pending_d;

`ifdef REGFILE_WB_RR_EN
  localparam int PW = $clog2(N_REQ);
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_ptr_d;

  wb_rr_arbiter #(.N(N_REQ)) u_arb (
    .valid    (req_valid_i),
    .ptr      (rr_ptr),
    .next_ptr (rr_ptr_d),
    .grant    (grant)
  );

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i)  rr_ptr <= '0;
    else if (accept) rr_ptr <= rr_ptr_d;
  end
`else
  wb_rr_arbiter #(.N(N_REQ)) u_arb (
    .valid (req_valid_i),
    .grant (grant)
  );
`endif

  // No grants while reset is held, so nothing can be accepted at a reset edge.
  assign req_ready_o = grant & {N_REQ{reset_n_i}};
  assign accept      = |req_ready_o;

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready_o[i]) begin
        sel.addr = req_addr_i[i];
        sel.data = req_data_i[i];
      end
    end
  end

  // Writes to $zero complete the handshake but never reach the regfile.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_enable_o <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
    end else begin
      wr_enable_o <= accept && (sel.addr != '0);
      if (accept && (sel.addr != '0)) begin
        wr_addr_o <= sel.addr;
        wr_data_o <= sel.data;
      end
    end
  end

  // Set is applied after clear so a same-edge reserve of the committing register wins.
  always_comb begin
    pending_d = pending_o;
    if (wr_enable_o) pending_d[wr_addr_o] = 1'b0;
    if (rsv_valid_i) pending_d[rsv_addr_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) pending_o <= '0;
    else            pending_o <= pending_d;
  end

  assign hazard_o = pending_o[rd_addr_1_i] | pending_o[rd_addr_2_i] | pending_o[rsv_addr_i];

  // Re-reserving a pending register is only legal on the edge where it commits.
  a_no_double_rsv : assert property (@(posedge clk) disable iff (!reset_n_i)
    rsv_valid_i |-> (!pending_o[rsv_addr_i] || (wr_enable_o && (wr_addr_o == rsv_addr_i))));

endmodule
